// File: rtl/uart_record_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_record_scheduler
// Description : Round-robin arbiter that latches one source word and paces the
//               binary-to-ASCII serializer (N bits + CR + LF) against the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_record_scheduler #(
  parameter int NREQ = 4,
  parameter int N    = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_16_x_baud,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*N-1:0]       req_data,
  input  logic                    tx_buffer_full,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] src_id,
  output logic                    busy,
  output logic [N-1:0]            binary_out,
  output logic                    send,
  output logic                    step
);

  localparam int c_chars = N + 2;
  localparam int c_cnt_w = $clog2(c_chars + 1);
  localparam int c_id_w  = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_cnt_w-1:0]  r_char_cnt;

  logic [2*NREQ-1:0]   w_rot;
  logic                w_found;
  logic [c_id_w-1:0]   w_offset;
  logic [c_id_w:0]     w_sum;
  logic [c_id_w-1:0]   w_winner;
  logic [c_id_w-1:0]   w_next_ptr;

  // Rotate the request vector so bit 0 is the source at rr_ptr, then take the
  // first set bit and map the offset back to an absolute index.
  always_comb begin
    w_rot    = {req, req} >> r_rr_ptr;
    w_found  = 1'b0;
    w_offset = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found  = 1'b1;
        w_offset = c_id_w'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    if (w_sum >= (c_id_w+1)'(NREQ)) begin
      w_sum = w_sum - (c_id_w+1)'(NREQ);
    end
    w_winner   = w_sum[c_id_w-1:0];
    w_next_ptr = (src_id == c_id_w'(NREQ-1)) ? '0 : src_id + 1'b1;
  end

  assign step = en_16_x_baud & ~tx_buffer_full & ~reset &
                ((r_state == S_LOAD) | (r_state == S_SEND));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      grant      <= '0;
      src_id     <= '0;
      busy       <= 1'b0;
      binary_out <= '0;
      send       <= 1'b0;
      r_rr_ptr   <= '0;
      r_char_cnt <= '0;
    end else begin
      grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            binary_out       <= req_data[w_winner*N +: N];
            src_id           <= w_winner;
            grant[w_winner]  <= 1'b1;
            busy             <= 1'b1;
            send             <= 1'b1;
            r_state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (step) begin
            send       <= 1'b0;
            r_char_cnt <= '0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (step) begin
            // The counter stops at CHARS-1; the final advance returns to IDLE instead.
            if (r_char_cnt == c_cnt_w'(c_chars-1)) begin
              busy     <= 1'b0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= S_IDLE;
            end else begin
              r_char_cnt <= r_char_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_record_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_record_scheduler
// Description : Directed scenarios plus randomized traffic checked every cycle
//               against a record-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_record_scheduler;
  localparam int NREQ  = 4;
  localparam int N     = 48;
  localparam int CHARS = N + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                en_16_x_baud;
  logic                tx_buffer_full;
  logic [NREQ-1:0]     req;
  logic [NREQ*N-1:0]   req_data;
  logic [NREQ-1:0]     grant;
  logic [1:0]          src_id;
  logic                busy;
  logic [N-1:0]        binary_out;
  logic                send;
  logic                step;

  uart_record_scheduler #(.NREQ(NREQ), .N(N)) dut (
    .clk(clk), .reset(reset), .en_16_x_baud(en_16_x_baud), .req(req),
    .req_data(req_data), .tx_buffer_full(tx_buffer_full), .grant(grant),
    .src_id(src_id), .busy(busy), .binary_out(binary_out), .send(send), .step(step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int glog[$];
  int rec_steps[$];
  int cur_steps = 0;
  logic prev_busy = 1'b0;
  logic [NREQ-1:0] hold_mask = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a record is CHARS+1 steps remaining; zero means idle.
  int              m_left = 0;
  int              m_ptr = 0;
  int              m_src = 0;
  logic [N-1:0]    m_data = '0;
  logic [NREQ-1:0] m_grant = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_ptr = 0; m_src = 0; m_data = '0; m_grant = '0;
    end else begin
      m_grant = '0;
      if (m_left > 0) begin
        if (en_16_x_baud && !tx_buffer_full) begin
          m_left--;
          if (m_left == 0) m_ptr = (m_src + 1) % NREQ;
        end
      end else if (req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (req[i]) begin
            m_src = i;
            break;
          end
        end
        m_data = req_data[m_src*N +: N];
        m_grant[m_src] = 1'b1;
        m_left = CHARS + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("grant", 64'(grant), 64'(m_grant));
      chk("src_id", 64'(src_id), 64'(m_src));
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("binary_out", 64'(binary_out), 64'(m_data));
      chk("send", 64'(send), 64'(m_left == CHARS + 1));
      chk("step", 64'(step), 64'(en_16_x_baud && !tx_buffer_full && m_left > 0));
      for (int k = 0; k < NREQ; k++) if (grant[k]) glog.push_back(k);
      if (step) cur_steps++;
      if (prev_busy && !busy) begin
        rec_steps.push_back(cur_steps);
        cur_steps = 0;
      end
      prev_busy = busy;
    end else begin
      cur_steps = 0;
      prev_busy = 1'b0;
    end
  end

  // One clock of stimulus; a granted source drops its request unless held.
  task automatic cyc();
    @(posedge clk);
    #2;
    req = req & ~(grant & ~hold_mask);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; en_16_x_baud = 1'b0; tx_buffer_full = 1'b0; hold_mask = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    glog.delete();
    rec_steps.delete();
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL timeout %s: got no event expected event at %0t", nm, $time);
  endtask

  task automatic wait_records(input int n, input int budget);
    int c = 0;
    while (rec_steps.size() < n && c < budget) begin cyc(); c++; end
    if (rec_steps.size() < n) timeout("records");
  endtask

  task automatic wait_steps(input int n, input int budget);
    int c = 0;
    while (cur_steps < n && c < budget) begin cyc(); c++; end
    if (cur_steps < n) timeout("steps");
  endtask

  int exp3[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = '0; req_data = '0; en_16_x_baud = 1'b0; tx_buffer_full = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_src", 64'(src_id), 64'd0);
    chk("rst_bin", 64'(binary_out), 64'd0);
    chk("rst_send", 64'(send), 64'd0);

    // T1: single record from source 0
    req_data[N-1:0] = 48'hA5A5_0000_FFFF;
    en_16_x_baud = 1'b1;
    req = 4'b0001;
    wait_records(1, 300);
    chk("t1_ngrant", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) chk("t1_src", 64'(glog[0]), 64'd0);
    if (rec_steps.size() > 0) chk("t1_steps", 64'(rec_steps[0]), 64'd51);
    chk("t1_bin", 64'(binary_out), 64'hA5A5_0000_FFFF);

    // T2: simultaneous requests 1 and 3 after reset
    do_reset();
    en_16_x_baud = 1'b1;
    req = 4'b1010;
    wait_records(2, 400);
    if (glog.size() >= 2) begin
      chk("t2_first", 64'(glog[0]), 64'd1);
      chk("t2_second", 64'(glog[1]), 64'd3);
    end else timeout("t2_grants");

    // T3: all sources held continuously
    do_reset();
    en_16_x_baud = 1'b1;
    hold_mask = 4'b1111;
    req = 4'b1111;
    wait_records(5, 1000);
    for (int k = 0; k < 5; k++) begin
      if (glog.size() > k) chk("t3_order", 64'(glog[k]), 64'(exp3[k]));
      if (rec_steps.size() > k) chk("t3_steps", 64'(rec_steps[k]), 64'd51);
    end

    // T4: FIFO full for 20 strobes at char_cnt=10
    do_reset();
    en_16_x_baud = 1'b1;
    req = 4'b0001;
    wait_steps(11, 200);
    tx_buffer_full = 1'b1;
    repeat (20) cyc();
    chk("t4_hold", 64'(cur_steps), 64'd11);
    chk("t4_nostep", 64'(step), 64'd0);
    tx_buffer_full = 1'b0;
    wait_records(1, 300);
    if (rec_steps.size() > 0) chk("t4_steps", 64'(rec_steps[0]), 64'd51);

    // T5: reset mid-record restores rr_ptr=0
    do_reset();
    en_16_x_baud = 1'b1;
    req = 4'b0100;
    wait_records(1, 300);
    if (glog.size() > 0) chk("t5_src2", 64'(glog[0]), 64'd2);
    req = 4'b0100;
    wait_steps(26, 300);
    reset = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_step", 64'(step), 64'd0);
    req = 4'b1001;
    @(posedge clk);
    #2;
    reset = 1'b0;
    glog.delete();
    rec_steps.delete();
    wait_records(1, 300);
    if (glog.size() > 0) chk("t5_ptr0", 64'(glog[0]), 64'd0);
    if (rec_steps.size() > 0) chk("t5_steps", 64'(rec_steps[0]), 64'd51);

    // T6: source 2 arrives while source 0 holds its request
    do_reset();
    en_16_x_baud = 1'b1;
    hold_mask = 4'b0001;
    req = 4'b0001;
    wait_steps(20, 200);
    req = req | 4'b0100;
    wait_records(2, 400);
    if (glog.size() >= 2) chk("t6_second", 64'(glog[1]), 64'd2);
    else timeout("t6_grants");

    // Randomized traffic with baud gaps and FIFO stalls
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cyc();
      en_16_x_baud = 1'($urandom_range(0, 1));
      tx_buffer_full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k] && $urandom_range(0, 39) == 0) begin
          req_data[k*N +: N] = N'({$urandom, $urandom});
          req[k] = 1'b1;
        end
      end
    end
    chk("rand_some", 64'(rec_steps.size() > 3), 64'd1);
    foreach (rec_steps[i]) chk("rand_steps", 64'(rec_steps[i]), 64'd51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
